axi_load_read_master: RTL and testbench
=======================================

Name: axi_load_read_master

Overview:
- Upstream neighbour of the load sign-extension stage in the single-cycle RV64 core.
- Accepts one load request (address + fun3) from the core and issues a single-beat AXI4 read on AR/R.
- Right-aligns the addressed bytes and zero-fills the unused upper bits. Sign extension happens downstream.
- Drives a stall/busy indication so the core holds the load instruction until resp_valid.

Parameters:
ADDR_W, 32, AXI/request address width
DATA_W, 64, AXI data width (fixed 64 for RV64; other values unsupported)
ID_W, 4, AXI ID width
ID_VAL, 0, constant ARID used for every read

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  1  load request present
req_ready  output  1  block can accept request (high only in IDLE)
req_addr  input  ADDR_W  byte address of load
req_fun3  input  3  load funct3 (000 lb, 001 lh, 010 lw, 011 ld, 1xx unsigned variants)
resp_valid  output  1  one-cycle pulse, result ready
resp_data  output  DATA_W  right-aligned, zero-filled load data
resp_err  output  1  misaligned address or AXI SLVERR/DECERR
busy  output  1  high from request accept until the resp_valid cycle inclusive
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
araddr  output  ADDR_W  AXI AR address (= latched req_addr)
arid  output  ID_W  = ID_VAL
arlen  output  8  always 0
arsize  output  3  {1'b0, fun3[1:0]}
arburst  output  2  always 2'b01 (INCR)
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready
rdata  input  DATA_W  AXI R data
rresp  input  2  AXI R response
rlast  input  1  AXI R last
rid  input  ID_W  AXI R id

Behaviour:
- FSM states: IDLE, AR, R, RESP. Reset forces IDLE.
- Reset values: arvalid=0, rready=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, latched addr/fun3=0.
- Reset mid-transaction abandons it. The interconnect shares the same reset.
- IDLE: req_ready=1. On req_valid, latch addr and fun3[1:0], then check alignment (addr mod 2^fun3[1:0] == 0).
  - Aligned: go to AR.
  - Misaligned: go to RESP with resp_err=1, resp_data=0. No AXI traffic.
- AR: arvalid=1. araddr/arsize/arid held stable until arready. On arvalid&arready go to R. arvalid never drops before the handshake.
- R: rready=1.
  - A beat with rid!=ID_VAL is accepted and discarded.
  - On rvalid & rid==ID_VAL & rlast: shifted = rdata >> (addr[2:0]*8).
  - Mask to width 8/16/32/64 bits per fun3[1:0]; upper bits 0.
  - resp_err = rresp[1]. Data is still registered when resp_err=1.
  - Go to RESP.
  - A matching beat without rlast is discarded (protocol violation; stay in R).
- RESP: resp_valid=1 for exactly one cycle; resp_data/resp_err valid that cycle and held until the next request. Then return to IDLE.
- req_ready=0 in RESP: a back-to-back request is accepted the cycle after RESP at the earliest.
- Minimum latency from req accept to resp_valid, with arready and rvalid both asserted immediately: accept at cycle 0, AR at 1, R at 2, RESP at 3.
- fun3[2] does not affect masking. Unsigned handling is done downstream.
- busy = (state != IDLE) | (req_valid & state==IDLE).

Test Plan:
1. ld at 0x8000_0000, arready/rvalid immediate, rdata=0x1122334455667788, rresp=0 -> arsize=3, araddr=0x80000000, resp_valid on cycle 3, resp_data=0x1122334455667788, resp_err=0.
2. lb at 0x8000_0005, rdata=0x1122334455667788 -> arsize=0, resp_data=0x0000000000000033; lhu at 0x8000_0006 -> resp_data=0x0000000000001122.
3. lw at 0x8000_0002 (misaligned) -> no arvalid ever, resp_valid one cycle later with resp_err=1, resp_data=0.
4. arready held low 5 cycles then high, rvalid delayed 3 cycles -> araddr/arsize stable throughout, busy high until the resp_valid cycle, one resp_valid pulse.
5. rresp=2'b10 on lw at 0x8000_0004, rdata=0xDEADBEEF_00000000 -> resp_err=1, resp_data=0x00000000DEADBEEF. A stray beat with rid=ID_VAL+1 before it is ignored.
6. Assert rst while in R state -> next cycle all outputs at reset values, state IDLE, req_ready=1.

Source files
------------

// File: rtl/axi_load_read_master.sv
// Single-beat AXI4 read master for RV64 loads: issues one AR/R transaction per
// request and returns the addressed bytes right-aligned and zero-filled.
module axi_load_read_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ID_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_fun3,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic              id_match;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] masked;

  // Signedness is resolved by the downstream sign-extension stage.
  logic unused_fun3_msb;
  assign unused_fun3_msb = req_fun3[2];

  always_comb begin
    misaligned = 1'b0;
    case (req_fun3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign id_match = (rid == ID_W'(ID_VAL));
  assign shifted  = rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    masked = '0;
    case (size_q)
      2'd0:    masked = DATA_W'(shifted[7:0]);
      2'd1:    masked = DATA_W'(shifted[15:0]);
      2'd2:    masked = DATA_W'(shifted[31:0]);
      default: masked = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_fun3[1:0];
          data_d  = '0;
          err_d   = misaligned;
          state_d = misaligned ? S_RESP : S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        // Foreign-ID beats and matching beats without rlast are consumed and dropped.
        if (rvalid && id_match && rlast) begin
          data_d  = masked;
          err_d   = rresp[1];
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE) | (req_valid & (state_q == S_IDLE));
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;

  assign arvalid = (state_q == S_AR);
  assign araddr  = addr_q;
  assign arid    = ID_W'(ID_VAL);
  assign arlen   = '0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign rready  = (state_q == S_R);

endmodule

// File: tb/tb_axi_load_read_master.sv
// Scoreboard bench for axi_load_read_master: directed loads plus randomized
// loads against a byte-level reference model, with a decoupled output monitor.
module tb_axi_load_read_master;

  localparam int unsigned ID_VAL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_fun3;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  axi_load_read_master #(
    .ADDR_W(32),
    .DATA_W(64),
    .ID_W  (4),
    .ID_VAL(ID_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_fun3  (req_fun3),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arid      (arid),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rid       (rid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] exp_resp[$];  // {data, err}
  logic [33:0] exp_ar[$];    // {addr, size}
  logic        outstanding = 1'b0;
  logic        mon_en      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] f);
    int unsigned n;
    n = 1 << f[1:0];
    return (a % n) != 0;
  endfunction

  // Gather the 2^size bytes starting at the byte offset within the 8-byte word.
  function automatic logic [63:0] ref_data(input logic [63:0] rd, input logic [31:0] a,
                                           input logic [2:0] f);
    logic [63:0] res;
    int unsigned n, off;
    res = '0;
    n   = 1 << f[1:0];
    off = a % 8;
    for (int unsigned i = 0; i < n; i++) res[i*8 +: 8] = rd[(off+i)*8 +: 8];
    return res;
  endfunction

  // Monitor: handshake-level model of req_ready/busy plus AR and response scoreboards.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("req_ready", 64'(req_ready), 64'(!outstanding));
        check("busy", 64'(busy), 64'(outstanding | (req_valid & !outstanding)));
        if (arvalid) begin
          if (exp_ar.size() == 0) begin
            check("ar_unexpected", 64'(arvalid), 64'd0);
          end else begin
            check("araddr", 64'(araddr), 64'(exp_ar[0][33:2]));
            check("arsize", 64'(arsize), 64'({1'b0, exp_ar[0][1:0]}));
            check("arlen_arburst_arid", {52'd0, arlen, arburst, arid},
                  {52'd0, 8'd0, 2'b01, 4'(ID_VAL)});
            if (arready) void'(exp_ar.pop_front());
          end
        end
        if (resp_valid) begin
          if (exp_resp.size() == 0) begin
            check("resp_unexpected", 64'(resp_valid), 64'd0);
          end else begin
            logic [64:0] e;
            e = exp_resp.pop_front();
            check("resp_data", resp_data, e[64:1]);
            check("resp_err", 64'(resp_err), 64'(e[0]));
          end
        end
        if (resp_valid) outstanding = 1'b0;
        else if (!outstanding && req_valid) outstanding = 1'b1;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that leaves RESP.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [63:0] rd,
                         input logic [1:0] rr, input int ar_dly, input int r_dly,
                         input int stray, input int exp_lat);
    logic mis;
    int   c0;
    bit   seen;
    mis = ref_misaligned(a, f);
    if (mis) exp_resp.push_back({64'd0, 1'b1});
    else begin
      exp_resp.push_back({ref_data(rd, a, f), rr[1]});
      exp_ar.push_back({a, f[1:0]});
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_fun3  = f;
    arready   = (ar_dly == 0);
    @(negedge clk);
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (!mis) begin
      if (ar_dly > 0) begin
        repeat (ar_dly) @(posedge clk);
        #1 arready = 1'b1;
      end
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = arvalid;
      end
      if (!seen) check("ar_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      arready = 1'b0;
      if (stray != 0) begin
        rvalid = 1'b1;
        rid    = (stray == 1) ? 4'(ID_VAL + 1) : 4'(ID_VAL);
        rlast  = (stray == 1);
        rdata  = ~rd;
        rresp  = 2'b00;
        @(posedge clk); #1;
        rvalid = 1'b0;
      end
      repeat (r_dly) begin
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rid    = 4'(ID_VAL);
      rlast  = 1'b1;
      rdata  = rd;
      rresp  = rr;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = rready;
      end
      if (!seen) check("r_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    if (!seen) check("resp_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) check("latency", 64'(cyc - c0), 64'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"},
          {58'd0, arvalid, rready, resp_valid, resp_err, busy, req_ready},
          {58'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    check({tag, "_resp_data"}, resp_data, 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_fun3 = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_init");
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_load(32'h8000_0000, 3'b011, 64'h1122334455667788, 2'b00, 0, 0, 0, 3);
    do_load(32'h8000_0005, 3'b000, 64'h1122334455667788, 2'b00, 0, 0, 0, 3);
    do_load(32'h8000_0006, 3'b101, 64'h1122334455667788, 2'b00, 0, 0, 0, 3);
    do_load(32'h8000_0002, 3'b010, 64'h1122334455667788, 2'b00, 0, 0, 0, 1);
    do_load(32'h8000_0010, 3'b011, 64'hA5A5_0F0F_1234_5678, 2'b00, 5, 3, 0, 0);
    do_load(32'h8000_0004, 3'b010, 64'hDEADBEEF_00000000, 2'b10, 0, 0, 1, 0);
    do_load(32'h8000_0008, 3'b001, 64'hCAFE_F00D_8765_4321, 2'b11, 1, 1, 2, 0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [2:0]  f;
      f = 3'($urandom_range(0, 7));
      a = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 32'd1);
      do_load(a, f, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

    // Abandon a transaction while waiting for the R beat.
    exp_ar.push_back({32'h8000_0018, 2'd3});
    req_valid = 1'b1; req_addr = 32'h8000_0018; req_fun3 = 3'b011; arready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_test_arvalid", 64'(arvalid), 64'd1);
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    check("rst_test_in_r", 64'(rready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    exp_ar.delete(); exp_resp.delete();
    outstanding = 1'b0; mon_en = 1'b1;

    do_load(32'h8000_0020, 3'b110, 64'h0102030405060708, 2'b00, 0, 0, 0, 3);
    repeat (2) @(posedge clk);
    check("queues_drained", 64'(exp_resp.size() + exp_ar.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
